// File: rtl/gate_sched_if.sv
// Gate scheduler signal bundle: lane requests and barrier feedback in, grants and lot status out.
// The master side drives requests and gate_done; the slave side is the scheduler.
interface gate_sched_if;
    logic [1:0] enter_req;
    logic       exit_req;
    logic       gate_done;
    logic [1:0] enter_gnt;
    logic       exit_gnt;
    logic [3:0] occ;
    logic       full;
    logic       busy;
    logic       timeout;
    logic [1:0] state_dbg;

    // Requests are levels held by a lane until its grant rises; a grant stays high
    // until gate_done (or the optional timer) ends the passage. No per-beat handshake.
    modport master (
        output enter_req, exit_req, gate_done,
        input  enter_gnt, exit_gnt, occ, full, busy, timeout, state_dbg
    );

    modport slave (
        input  enter_req, exit_req, gate_done,
        output enter_gnt, exit_gnt, occ, full, busy, timeout, state_dbg
    );
endinterface

// File: rtl/gate_sched.sv
// Parking-lot barrier scheduler: one exit lane and two round-robin entry lanes share one passage at a time.
// Optional passage timer enabled by defining GATE_SCHED_TIMEOUT_EN.
module gate_sched #(
    parameter int CAPACITY = 15,
    parameter int TIMEOUT  = 255
) (
    input  logic         clk,
    input  logic         reset,
    gate_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    localparam logic [3:0] CAP = 4'(CAPACITY);

    if (CAPACITY < 1 || CAPACITY > 15) begin : g_bad_capacity
        $error("gate_sched: CAPACITY out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("gate_sched: TIMEOUT out of range");
    end

    state_e     state_q, state_d;
    logic [1:0] enter_gnt_q, enter_gnt_d;
    logic       exit_gnt_q, exit_gnt_d;
    logic [3:0] occ_q, occ_d;
    logic       rr_q, rr_d;
    logic       lane;

`ifdef GATE_SCHED_TIMEOUT_EN
    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
    logic [7:0] timer_q, timer_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        enter_gnt_d = enter_gnt_q;
        exit_gnt_d  = exit_gnt_q;
        occ_d       = occ_q;
        rr_d        = rr_q;
        lane        = rr_q;
`ifdef GATE_SCHED_TIMEOUT_EN
        timer_d     = timer_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // Exit has priority so a full lot can always drain.
                if (bus.exit_req && occ_q != 4'd0) begin
                    exit_gnt_d = 1'b1;
                    state_d    = S_OPEN;
`ifdef GATE_SCHED_TIMEOUT_EN
                    timer_d    = 8'd0;
`endif
                end else if (occ_q < CAP && bus.enter_req != 2'b00) begin
                    lane        = bus.enter_req[rr_q] ? rr_q : ~rr_q;
                    enter_gnt_d = lane ? 2'b10 : 2'b01;
                    rr_d        = ~lane;
                    state_d     = S_OPEN;
`ifdef GATE_SCHED_TIMEOUT_EN
                    timer_d     = 8'd0;
`endif
                end
            end
            S_OPEN: begin
                if (bus.gate_done) begin
                    enter_gnt_d = 2'b00;
                    exit_gnt_d  = 1'b0;
                    state_d     = S_COMMIT;
                    if (enter_gnt_q != 2'b00 && occ_q < CAP) begin
                        occ_d = occ_q + 4'd1;
                    end else if (exit_gnt_q && occ_q != 4'd0) begin
                        occ_d = occ_q - 4'd1;
                    end
                end
`ifdef GATE_SCHED_TIMEOUT_EN
                // Aborted passage: the vehicle never went through, so occupancy holds.
                else if (timer_q == TLIM) begin
                    enter_gnt_d = 2'b00;
                    exit_gnt_d  = 1'b0;
                    state_d     = S_COMMIT;
                    timeout_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
`endif
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                enter_gnt_d = 2'b00;
                exit_gnt_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            enter_gnt_q <= 2'b00;
            exit_gnt_q  <= 1'b0;
            occ_q       <= 4'd0;
            rr_q        <= 1'b0;
`ifdef GATE_SCHED_TIMEOUT_EN
            timer_q     <= 8'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            enter_gnt_q <= enter_gnt_d;
            exit_gnt_q  <= exit_gnt_d;
            occ_q       <= occ_d;
            rr_q        <= rr_d;
`ifdef GATE_SCHED_TIMEOUT_EN
            timer_q     <= timer_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bus.enter_gnt = enter_gnt_q;
    assign bus.exit_gnt  = exit_gnt_q;
    assign bus.occ       = occ_q;
    assign bus.full      = (occ_q == CAP);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.state_dbg = state_q;
`ifdef GATE_SCHED_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: doc/gate_sched.md
GATE_SCHED -- requirements
Module: gate_sched

Interface
REQ-001 Parameter CAPACITY, default 15, maximum lot occupancy (1..15).
REQ-002 Parameter TIMEOUT, default 255, OPEN-state cycle limit (1..255, 8-bit timer).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enter_req  input  2  per-entry-lane request, level, held by lane until granted.
REQ-006 exit_req  input  1  exit-lane request, level, held until granted.
REQ-007 gate_done  input  1  barrier reports vehicle passed and gate closed.
REQ-008 enter_gnt  output  2  one-hot entry-lane gate-open grant, registered.
REQ-009 exit_gnt  output  1  exit-lane gate-open grant, registered.
REQ-010 occ  output  4  current occupancy count.
REQ-011 full  output  1  high when occ == CAPACITY.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 timeout  output  1  one-cycle pulse on aborted passage.

Function
REQ-014 FSM states: IDLE, OPEN, COMMIT; IDLE is the only state that accepts requests.
REQ-015 At most one of enter_gnt[1:0], exit_gnt is high in any cycle.
REQ-016 IDLE arbitration, highest first: exit_req if occ > 0; then entry lanes if occ < CAPACITY, round-robin.
REQ-017 Round-robin pointer names the preferred entry lane; reset value lane 0; set to the other lane on each entry grant.
REQ-018 Entry requests when full, and exit_req when occ == 0, are not granted and stay pending without error.
REQ-019 Request sampled in IDLE at edge N: grant high from edge N, state OPEN; grant-to-request latency one cycle.
REQ-020 OPEN: grant held until gate_done sampled high.
REQ-021 OPEN with gate_done high at edge M: grant low, state COMMIT, occ +1 (entry) or -1 (exit) at edge M.
REQ-022 COMMIT lasts exactly one cycle, grants low, then IDLE; back-to-back grants are separated by at least one idle cycle.
REQ-023 gate_done outside OPEN is ignored.
REQ-024 occ never exceeds CAPACITY nor wraps below 0; full and busy are combinational from occ and state.
REQ-025 A request dropped mid-OPEN does not cancel the grant; only gate_done or timeout ends OPEN.

Reset
REQ-026 reset high at an edge: state IDLE, occ 0, all grants 0, timeout 0, RR pointer lane 0, timer 0.
REQ-027 reset has priority over every event, including gate_done in the same cycle; reset during OPEN drops the grant at that edge.

Configuration
REQ-028 Macro GATE_SCHED_TIMEOUT_EN defined: 8-bit timer clears on OPEN entry, increments each OPEN cycle without gate_done; at TIMEOUT, grant low, state COMMIT, occ unchanged, timeout pulses one cycle.
REQ-029 Macro undefined: no timer; OPEN waits indefinitely; timeout port present and tied 0.
REQ-030 gate_done and timer expiry in the same cycle: gate_done wins, occ updated, no timeout pulse.

Verification
REQ-031 Reset, enter_req=01, gate_done after 3 cycles -> enter_gnt=01 at edge 1 for 4 cycles, occ=1, busy low after COMMIT.
REQ-032 enter_req=11 held, gate_done each OPEN -> grants alternate 01,10,01,10; occ 1,2,3,4.
REQ-033 CAPACITY=2, occ=2, enter_req=01 and exit_req=1 -> exit_gnt first, occ=1, then enter_gnt=01, occ=2, full=1.
REQ-034 occ=0, exit_req=1 for 20 cycles -> no grant, busy=0, occ=0.
REQ-035 TIMEOUT_EN, TIMEOUT=4, enter_req=10, no gate_done -> enter_gnt=10 four cycles, timeout pulse, occ unchanged.
REQ-036 Reset asserted during OPEN with gate_done -> grant 0 and occ 0 next edge; no increment.
